// File: rtl/axi_id_remap_pkg.sv
// Shared types and lookup helper for the AXI ID remapper.
// One slot table per direction; slot index is the narrow ID.
package axi_id_remap_pkg;

  localparam int unsigned ID_IN_W  = 6;
  localparam int unsigned ID_OUT_W = 2;
  localparam int unsigned N_SLOTS  = 1 << ID_OUT_W;
  localparam int unsigned MAX_TXNS = 4;
  localparam int unsigned CNT_W    = $clog2(MAX_TXNS + 1);

  typedef struct packed {
    logic [ID_IN_W-1:0] orig_id;
    logic [CNT_W-1:0]   cnt;
  } slot_t;

  typedef slot_t [N_SLOTS-1:0] table_t;

  typedef struct packed {
    logic                hit;
    logic [ID_OUT_W-1:0] hit_idx;
    logic                free;
    logic [ID_OUT_W-1:0] free_idx;
  } lookup_t;

  // Descending scan so the lowest free index wins.
  function automatic lookup_t lookup(
    input table_t             tbl,
    input logic [ID_IN_W-1:0] id
  );
    lookup_t r;
    r = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (tbl[i].cnt != '0 && tbl[i].orig_id == id) begin
        r.hit     = 1'b1;
        r.hit_idx = ID_OUT_W'(i);
      end
      if (tbl[i].cnt == '0) begin
        r.free     = 1'b1;
        r.free_idx = ID_OUT_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_bus.sv
// Generic AXI4 bus bundle with master/slave views.
// Widths are set per instance.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 6
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]         w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_lock, aw_cache, aw_prot, aw_qos, aw_user,
    output aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input w_ready,
    input b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_lock, ar_cache, ar_prot, ar_qos, ar_user,
    output ar_valid, input ar_ready,
    input r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input aw_lock, aw_cache, aw_prot, aw_qos, aw_user,
    input aw_valid, output aw_ready,
    input w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input ar_lock, ar_cache, ar_prot, ar_qos, ar_user,
    input ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input r_ready
  );
endinterface

// File: rtl/axi_id_remap_table.sv
// Per-direction slot table: pins each in-flight wide ID to one
// slot, counts outstanding txns, restores the ID on responses.
module axi_id_remap_table
  import axi_id_remap_pkg::*;
#(
  parameter int unsigned MAX = MAX_TXNS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ID_IN_W-1:0]  req_id_i,
  input  logic                req_hs_i,
  input  logic [ID_OUT_W-1:0] rsp_id_i,
  input  logic                rsp_done_i,
  output logic [ID_OUT_W-1:0] slot_o,
  output logic                stall_o,
  output logic [ID_IN_W-1:0]  orig_o
);

  table_t  tbl_q, tbl_d;
  lookup_t look;

  assign look    = lookup(tbl_q, req_id_i);
  assign slot_o  = look.hit ? look.hit_idx : look.free_idx;
  assign stall_o = look.hit
                 ? (tbl_q[look.hit_idx].cnt == CNT_W'(MAX))
                 : !look.free;
  assign orig_o  = tbl_q[rsp_id_i].orig_id;

  always_comb begin
    tbl_d = tbl_q;
    for (int i = 0; i < N_SLOTS; i++) begin
      logic inc, dec;
      inc = req_hs_i && (slot_o == ID_OUT_W'(i));
      dec = rsp_done_i && (rsp_id_i == ID_OUT_W'(i))
            && (tbl_q[i].cnt != '0);
      if (inc && !look.hit) begin
        tbl_d[i].orig_id = req_id_i;
        tbl_d[i].cnt     = CNT_W'(1);
      end else if (inc && !dec) begin
        tbl_d[i].cnt = tbl_q[i].cnt + CNT_W'(1);
      end else if (!inc && dec) begin
        tbl_d[i].cnt = tbl_q[i].cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) tbl_q <= '0;
    else       tbl_q <= tbl_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && rsp_done_i)
      assert (tbl_q[rsp_id_i].cnt != '0)
        else $error("response for idle slot %0d", rsp_id_i);
  end
`endif

endmodule

// File: rtl/axi_id_remapper.sv
// Narrows the AXI ID of one port to a slot index and
// restores it on R/B. Channel wiring around two slot tables.
module axi_id_remapper
  import axi_id_remap_pkg::*;
#(
  parameter int unsigned AXI_ADDR_W   = 32,
  parameter int unsigned AXI_DATA_W   = 64,
  parameter int unsigned AXI_USER_W   = 6,
  parameter int unsigned AXI_ID_IN_W  = ID_IN_W,
  parameter int unsigned AXI_ID_OUT_W = ID_OUT_W,
  parameter int unsigned MAX_TXNS_P   = MAX_TXNS
) (
  input  logic   clk,
  input  logic   rst,
  AXI_BUS.Slave  axi_slave,
  AXI_BUS.Master axi_master
);

  logic [AXI_ID_OUT_W-1:0] ar_slot, aw_slot;
  logic [AXI_ID_IN_W-1:0]  r_orig, b_orig;
  logic                    ar_stall, aw_stall;
  logic                    ar_hs, aw_hs, r_done, b_done;
  logic [AXI_ADDR_W-1:0]   ar_addr, aw_addr;
  logic [AXI_DATA_W-1:0]   w_data, r_data;
  logic [AXI_USER_W-1:0]   ar_user, aw_user;

  assign ar_hs  = axi_master.ar_valid && axi_master.ar_ready;
  assign aw_hs  = axi_master.aw_valid && axi_master.aw_ready;
  assign r_done = axi_master.r_valid && axi_slave.r_ready
                  && axi_master.r_last;
  assign b_done = axi_master.b_valid && axi_slave.b_ready;

  axi_id_remap_table #(.MAX(MAX_TXNS_P)) u_rd_tbl (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_id_i   (axi_slave.ar_id),
    .req_hs_i   (ar_hs),
    .rsp_id_i   (axi_master.r_id),
    .rsp_done_i (r_done),
    .slot_o     (ar_slot),
    .stall_o    (ar_stall),
    .orig_o     (r_orig)
  );

  axi_id_remap_table #(.MAX(MAX_TXNS_P)) u_wr_tbl (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_id_i   (axi_slave.aw_id),
    .req_hs_i   (aw_hs),
    .rsp_id_i   (axi_master.b_id),
    .rsp_done_i (b_done),
    .slot_o     (aw_slot),
    .stall_o    (aw_stall),
    .orig_o     (b_orig)
  );

  // AR: valid gated by stall so nothing leaks downstream
  assign ar_addr             = axi_slave.ar_addr;
  assign ar_user             = axi_slave.ar_user;
  assign axi_master.ar_id    = ar_slot;
  assign axi_master.ar_addr  = ar_addr;
  assign axi_master.ar_len   = axi_slave.ar_len;
  assign axi_master.ar_size  = axi_slave.ar_size;
  assign axi_master.ar_burst = axi_slave.ar_burst;
  assign axi_master.ar_lock  = axi_slave.ar_lock;
  assign axi_master.ar_cache = axi_slave.ar_cache;
  assign axi_master.ar_prot  = axi_slave.ar_prot;
  assign axi_master.ar_qos   = axi_slave.ar_qos;
  assign axi_master.ar_user  = ar_user;
  assign axi_master.ar_valid = axi_slave.ar_valid && !ar_stall;
  assign axi_slave.ar_ready  = axi_master.ar_ready && !ar_stall;

  assign aw_addr             = axi_slave.aw_addr;
  assign aw_user             = axi_slave.aw_user;
  assign axi_master.aw_id    = aw_slot;
  assign axi_master.aw_addr  = aw_addr;
  assign axi_master.aw_len   = axi_slave.aw_len;
  assign axi_master.aw_size  = axi_slave.aw_size;
  assign axi_master.aw_burst = axi_slave.aw_burst;
  assign axi_master.aw_lock  = axi_slave.aw_lock;
  assign axi_master.aw_cache = axi_slave.aw_cache;
  assign axi_master.aw_prot  = axi_slave.aw_prot;
  assign axi_master.aw_qos   = axi_slave.aw_qos;
  assign axi_master.aw_user  = aw_user;
  assign axi_master.aw_valid = axi_slave.aw_valid && !aw_stall;
  assign axi_slave.aw_ready  = axi_master.aw_ready && !aw_stall;

  assign w_data              = axi_slave.w_data;
  assign axi_master.w_data   = w_data;
  assign axi_master.w_strb   = axi_slave.w_strb;
  assign axi_master.w_last   = axi_slave.w_last;
  assign axi_master.w_user   = axi_slave.w_user;
  assign axi_master.w_valid  = axi_slave.w_valid;
  assign axi_slave.w_ready   = axi_master.w_ready;

  assign r_data              = axi_master.r_data;
  assign axi_slave.r_id      = r_orig;
  assign axi_slave.r_data    = r_data;
  assign axi_slave.r_resp    = axi_master.r_resp;
  assign axi_slave.r_last    = axi_master.r_last;
  assign axi_slave.r_user    = axi_master.r_user;
  assign axi_slave.r_valid   = axi_master.r_valid;
  assign axi_master.r_ready  = axi_slave.r_ready;

  assign axi_slave.b_id      = b_orig;
  assign axi_slave.b_resp    = axi_master.b_resp;
  assign axi_slave.b_user    = axi_master.b_user;
  assign axi_slave.b_valid   = axi_master.b_valid;
  assign axi_master.b_ready  = axi_slave.b_ready;

endmodule

// File: tb/tb_axi_id_remapper.sv
// Directed bench for axi_id_remapper with an outstanding-txn
// list model checked every cycle on the falling edge.
module tb_axi_id_remapper;

  localparam int NS  = 4;
  localparam int MAX = 4;

  typedef struct {
    logic [5:0] id;
    int         slot;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  txn_t rdq[$];
  txn_t wrq[$];

  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64),
            .AXI_ID_WIDTH(6), .AXI_USER_WIDTH(6)) slv ();
  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64),
            .AXI_ID_WIDTH(2), .AXI_USER_WIDTH(6)) mst ();

  axi_id_remapper dut (
    .clk        (clk),
    .rst        (rst),
    .axi_slave  (slv),
    .axi_master (mst)
  );

  function automatic void chk(input string name,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endfunction

  // Expected slot/stall from the set of outstanding txns.
  function automatic void mdl_req(input txn_t q[$],
                                  input logic [5:0] id,
                                  output bit stall,
                                  output int slot);
    int hits = 0;
    int hs = -1;
    bit used[NS];
    foreach (used[s]) used[s] = 1'b0;
    foreach (q[k]) begin
      used[q[k].slot] = 1'b1;
      if (q[k].id == id) begin
        hits++;
        hs = q[k].slot;
      end
    end
    if (hits > 0) begin
      slot  = hs;
      stall = (hits >= MAX);
    end else begin
      slot = -1;
      for (int s = NS - 1; s >= 0; s--)
        if (!used[s]) slot = s;
      stall = (slot < 0);
    end
  endfunction

  function automatic int mdl_find(input txn_t q[$], input int slot);
    foreach (q[k])
      if (q[k].slot == slot) return k;
    return -1;
  endfunction

  always @(negedge clk) begin
    bit st_r, st_w;
    int sl_r, sl_w, k;
    bit push_r, push_w;
    mdl_req(rdq, slv.ar_id, st_r, sl_r);
    mdl_req(wrq, slv.aw_id, st_w, sl_w);
    if (slv.ar_valid) begin
      chk("ar_valid", mst.ar_valid, !st_r);
      chk("ar_ready", slv.ar_ready, mst.ar_ready && !st_r);
      if (!st_r) chk("ar_id", mst.ar_id, sl_r);
      chk("ar_addr", mst.ar_addr, slv.ar_addr);
    end else chk("ar_valid_idle", mst.ar_valid, 0);
    if (slv.aw_valid) begin
      chk("aw_valid", mst.aw_valid, !st_w);
      chk("aw_ready", slv.aw_ready, mst.aw_ready && !st_w);
      if (!st_w) chk("aw_id", mst.aw_id, sl_w);
      chk("aw_addr", mst.aw_addr, slv.aw_addr);
    end else chk("aw_valid_idle", mst.aw_valid, 0);
    if (mst.r_valid) begin
      k = mdl_find(rdq, mst.r_id);
      if (k >= 0) chk("r_id", slv.r_id, rdq[k].id);
      chk("r_data", slv.r_data, mst.r_data);
      chk("r_last", slv.r_last, mst.r_last);
    end
    chk("r_valid", slv.r_valid, mst.r_valid);
    chk("r_ready", mst.r_ready, slv.r_ready);
    if (mst.b_valid) begin
      k = mdl_find(wrq, mst.b_id);
      if (k >= 0) chk("b_id", slv.b_id, wrq[k].id);
    end
    chk("b_valid", slv.b_valid, mst.b_valid);
    chk("w_valid", mst.w_valid, slv.w_valid);
    chk("w_ready", slv.w_ready, mst.w_ready);
    if (slv.w_valid) chk("w_data", mst.w_data, slv.w_data);
    push_r = slv.ar_valid && !st_r && mst.ar_ready;
    push_w = slv.aw_valid && !st_w && mst.aw_ready;
    if (rst) begin
      rdq.delete();
      wrq.delete();
    end else begin
      if (mst.r_valid && slv.r_ready && mst.r_last) begin
        k = mdl_find(rdq, mst.r_id);
        if (k >= 0) rdq.delete(k);
      end
      if (mst.b_valid && slv.b_ready) begin
        k = mdl_find(wrq, mst.b_id);
        if (k >= 0) wrq.delete(k);
      end
      if (push_r) rdq.push_back('{slv.ar_id, sl_r});
      if (push_w) wrq.push_back('{slv.aw_id, sl_w});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_send(input logic [5:0] id,
                         input logic [1:0] exp);
    bit done = 1'b0;
    slv.ar_valid = 1'b1;
    slv.ar_id    = id;
    slv.ar_addr  = $urandom;
    for (int n = 0; n < 16 && !done; n++) begin
      @(negedge clk);
      if (mst.ar_valid && mst.ar_ready) begin
        done = 1'b1;
        chk("ar_slot_lit", mst.ar_id, exp);
      end
      tick();
    end
    if (!done) tmo("ar_send");
    slv.ar_valid = 1'b0;
  endtask

  task automatic aw_send(input logic [5:0] id,
                         input logic [1:0] exp);
    bit done = 1'b0;
    slv.aw_valid = 1'b1;
    slv.aw_id    = id;
    slv.aw_addr  = $urandom;
    for (int n = 0; n < 16 && !done; n++) begin
      @(negedge clk);
      if (mst.aw_valid && mst.aw_ready) begin
        done = 1'b1;
        chk("aw_slot_lit", mst.aw_id, exp);
      end
      tick();
    end
    if (!done) tmo("aw_send");
    slv.aw_valid = 1'b0;
  endtask

  task automatic r_send(input logic [1:0] slot, input bit last,
                        input logic [5:0] exp);
    mst.r_valid = 1'b1;
    mst.r_id    = slot;
    mst.r_last  = last;
    mst.r_data  = {$urandom, $urandom};
    @(negedge clk);
    chk("rid_lit", slv.r_id, exp);
    tick();
    mst.r_valid = 1'b0;
    mst.r_last  = 1'b0;
  endtask

  task automatic b_send(input logic [1:0] slot,
                        input logic [5:0] exp);
    mst.b_valid = 1'b1;
    mst.b_id    = slot;
    @(negedge clk);
    chk("bid_lit", slv.b_id, exp);
    tick();
    mst.b_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    slv.ar_valid = 0; slv.ar_id = 0; slv.ar_addr = 0;
    slv.ar_len = 0; slv.ar_size = 3; slv.ar_burst = 1;
    slv.ar_lock = 0; slv.ar_cache = 0; slv.ar_prot = 0;
    slv.ar_qos = 0; slv.ar_user = 0;
    slv.aw_valid = 0; slv.aw_id = 0; slv.aw_addr = 0;
    slv.aw_len = 0; slv.aw_size = 3; slv.aw_burst = 1;
    slv.aw_lock = 0; slv.aw_cache = 0; slv.aw_prot = 0;
    slv.aw_qos = 0; slv.aw_user = 0;
    slv.w_valid = 0; slv.w_data = 0; slv.w_strb = '1;
    slv.w_last = 1; slv.w_user = 0;
    slv.r_ready = 1; slv.b_ready = 1;
    mst.ar_ready = 1; mst.aw_ready = 1; mst.w_ready = 1;
    mst.r_valid = 0; mst.r_id = 0; mst.r_data = 0;
    mst.r_resp = 0; mst.r_last = 0; mst.r_user = 0;
    mst.b_valid = 0; mst.b_id = 0; mst.b_resp = 0;
    mst.b_user = 0;

    // reset: ready follows downstream ready
    repeat (2) tick();
    mst.ar_ready = 0;
    @(negedge clk);
    chk("arready_rst_lo", slv.ar_ready, 0);
    tick();
    mst.ar_ready = 1;
    @(negedge clk);
    chk("arready_rst_hi", slv.ar_ready, 1);
    chk("awready_rst_hi", slv.aw_ready, 1);
    tick();
    rst = 0;
    tick();

    ar_send(6'h2A, 2'd0);
    r_send(2'd0, 1'b1, 6'h2A);
    ar_send(6'h07, 2'd0);
    r_send(2'd0, 1'b1, 6'h07);

    // same-ID ordering
    ar_send(6'h05, 2'd0);
    ar_send(6'h05, 2'd0);
    ar_send(6'h05, 2'd0);
    ar_send(6'h09, 2'd1);
    r_send(2'd0, 1'b0, 6'h05);
    r_send(2'd0, 1'b1, 6'h05);
    r_send(2'd0, 1'b1, 6'h05);
    r_send(2'd0, 1'b1, 6'h05);
    r_send(2'd1, 1'b1, 6'h09);

    // table full
    aw_send(6'h10, 2'd0);
    aw_send(6'h11, 2'd1);
    aw_send(6'h12, 2'd2);
    aw_send(6'h13, 2'd3);
    slv.aw_valid = 1;
    slv.aw_id    = 6'h14;
    repeat (3) begin
      @(negedge clk);
      chk("aw_full_ready", slv.aw_ready, 0);
      chk("aw_full_valid", mst.aw_valid, 0);
      tick();
    end
    mst.b_valid = 1;
    mst.b_id    = 2'd2;
    @(negedge clk);
    chk("bid_free_lit", slv.b_id, 6'h12);
    chk("aw_free_late", slv.aw_ready, 0);
    tick();
    mst.b_valid = 0;
    @(negedge clk);
    chk("aw_realloc_valid", mst.aw_valid, 1);
    chk("aw_realloc_slot", mst.aw_id, 2);
    tick();
    slv.aw_valid = 0;
    b_send(2'd0, 6'h10);
    b_send(2'd1, 6'h11);
    b_send(2'd2, 6'h14);
    b_send(2'd3, 6'h13);

    // slot full
    repeat (MAX) ar_send(6'h11, 2'd0);
    slv.ar_valid = 1;
    slv.ar_id    = 6'h11;
    repeat (2) begin
      @(negedge clk);
      chk("ar_slotfull_ready", slv.ar_ready, 0);
      tick();
    end
    mst.r_valid = 1; mst.r_id = 0; mst.r_last = 1;
    @(negedge clk);
    chk("ar_slotfull_same", slv.ar_ready, 0);
    chk("rid_slotfull", slv.r_id, 6'h11);
    tick();
    mst.r_valid = 0; mst.r_last = 0;
    @(negedge clk);
    chk("ar_slotfull_go", mst.ar_valid, 1);
    chk("ar_slotfull_id", mst.ar_id, 0);
    tick();
    slv.ar_valid = 0;
    repeat (MAX) r_send(2'd0, 1'b1, 6'h11);

    // simultaneous hit + rlast, then miss as a slot frees
    ar_send(6'h20, 2'd0);
    slv.ar_valid = 1; slv.ar_id = 6'h20;
    mst.r_valid = 1; mst.r_id = 0; mst.r_last = 1;
    @(negedge clk);
    chk("sim_hit_id", mst.ar_id, 0);
    chk("sim_hit_valid", mst.ar_valid, 1);
    tick();
    slv.ar_id = 6'h31;
    @(negedge clk);
    chk("sim_miss_id", mst.ar_id, 1);
    tick();
    slv.ar_valid = 0;
    mst.r_valid = 0; mst.r_last = 0;
    ar_send(6'h32, 2'd0);
    r_send(2'd1, 1'b1, 6'h31);
    r_send(2'd0, 1'b1, 6'h32);

    // reset mid-burst
    aw_send(6'h01, 2'd0);
    aw_send(6'h02, 2'd1);
    aw_send(6'h03, 2'd2);
    rst = 1;
    tick();
    rst = 0;
    aw_send(6'h03, 2'd0);
    aw_send(6'h04, 2'd1);
    b_send(2'd0, 6'h03);
    b_send(2'd1, 6'h04);

    // randomised R/W backpressure
    ar_send(6'h3C, 2'd0);
    beats = 0;
    for (int n = 0; n < 200 && beats < 4; n++) begin
      mst.r_valid  = 1'($urandom_range(0, 1));
      mst.r_id     = 0;
      mst.r_last   = (beats == 3);
      mst.r_data   = {$urandom, $urandom};
      slv.r_ready  = 1'($urandom_range(0, 1));
      slv.w_valid  = 1'($urandom_range(0, 1));
      slv.w_data   = {$urandom, $urandom};
      mst.w_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (mst.r_valid && slv.r_ready) beats++;
      tick();
    end
    if (beats < 4) tmo("r_burst");
    mst.r_valid = 0; mst.r_last = 0;
    slv.r_ready = 1; slv.w_valid = 0; mst.w_ready = 1;
    ar_send(6'h3D, 2'd0);
    r_send(2'd0, 1'b1, 6'h3D);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
